load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_align.sv | 83 ++++++++
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types for the load/store unit: access-size encoding, FSM state
// encoding and the misalignment predicate.
// Configuration macro: LSU_MISALIGN_TRAP_EN adds the ERR state and the
// misaligned / illegal-size trap. Without it, ERR does not exist.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_X = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD      = 3'd1,
        LD_WAIT = 3'd2,
        ST_W    = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        ERR     = 3'd6
`endif
    } lsu_state_e;

    // True when the address is not naturally aligned for the size, or the
    // size code is the illegal one.
    function automatic logic lsu_misaligned(input lsu_size_e size,
                                            input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational little-endian lane handling for the load/store unit.
// Ports:
//   i_size       access size (size code 11 behaves as a word)
//   i_addr_lo    byte offset within the word
//   i_unsigned   1 = zero-extend loads, 0 = sign-extend
//   i_rdata      word read from memory
//   i_wdata      right-justified store data
//   o_load_data  selected lane, extended to 32 bits
//   o_merge_data i_rdata with the target lane replaced by store data
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_unsigned,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction and sign/zero extension for loads.
    always_comb begin
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
        case (i_size)
            SIZE_B: begin
                if (i_unsigned) begin
                    o_load_data = {24'h000000, w_byte};
                end else begin
                    o_load_data = {{24{w_byte[7]}}, w_byte};
                end
            end
            SIZE_H: begin
                if (i_unsigned) begin
                    o_load_data = {16'h0000, w_half};
                end else begin
                    o_load_data = {{16{w_half[15]}}, w_half};
                end
            end
            default: o_load_data = i_rdata;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes store data.
    always_comb begin
        o_merge_data = i_rdata;
        case (i_size)
            SIZE_B: begin
                case (i_addr_lo)
                    2'b00:   o_merge_data[7:0]   = i_wdata[7:0];
                    2'b01:   o_merge_data[15:8]  = i_wdata[7:0];
                    2'b10:   o_merge_data[23:16] = i_wdata[7:0];
                    default: o_merge_data[31:24] = i_wdata[7:0];
                endcase
            end
            SIZE_H: begin
                if (i_addr_lo[1]) begin
                    o_merge_data[31:16] = i_wdata[15:0];
                end else begin
                    o_merge_data[15:0] = i_wdata[15:0];
                end
            end
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding load/store unit in front of a word-wide data memory with
// one-cycle read latency. Byte and half stores use a read-modify-write.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion pulse, no back-pressure
//   mem_read, mem_write, mem_addr, mem_wdata, mem_rdata   data memory port
// Parameter WORD_IDX_W: width of the word index driven on mem_addr.
// Configuration macro: LSU_MISALIGN_TRAP_EN routes misaligned / illegal-size
// requests to ERR; undefined, low address bits are ignored and size 11 acts
// as a word.
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_IDX_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e             r_state;
    lsu_state_e             w_state_nxt;
    lsu_state_e             w_dispatch;
    lsu_size_e              r_size;
    logic                   r_unsigned;
    logic [1:0]             r_addr_lo;
    logic [31:0]            r_wdata;
    logic [WORD_IDX_W-1:0]  r_word_idx;
    logic [31:0]            r_mem_wdata;
    logic                   w_accept;
    logic                   w_sub_word;
    logic [31:0]            w_load_data;
    logic [31:0]            w_merge_data;
    logic [31:0]            w_mem_wdata;
    logic                   w_unused_addr;

    // Address bits above the word index never reach the memory.
    assign w_unused_addr = ^req_addr[31:WORD_IDX_W+2];

    assign w_accept   = req_valid && req_ready;
    assign w_sub_word = (req_size == SIZE_B) || (req_size == SIZE_H);
    assign mem_addr   = {{(32-WORD_IDX_W){1'b0}}, r_word_idx};
    assign mem_wdata  = w_mem_wdata;

    lsu_align u_align (
        .i_size       (r_size),
        .i_addr_lo    (r_addr_lo),
        .i_unsigned   (r_unsigned),
        .i_rdata      (mem_rdata),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // First active state for a request offered in IDLE.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (lsu_misaligned(lsu_size_e'(req_size), req_addr[1:0])) begin
            w_dispatch = ERR;
        end else if (!req_we) begin
            w_dispatch = LD;
        end else if (w_sub_word) begin
            w_dispatch = RMW_RD;
        end else begin
            w_dispatch = ST_W;
        end
`else
        if (!req_we) begin
            w_dispatch = LD;
        end else if (w_sub_word) begin
            w_dispatch = RMW_RD;
        end else begin
            w_dispatch = ST_W;
        end
`endif
    end

    // Next-state and Moore output decode.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_rdata   = 32'h0000_0000;
        rsp_err     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        w_mem_wdata = r_mem_wdata;
        case (r_state)
            IDLE: begin
                // Gated by rst_n so ready reads 0 while reset is held.
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    w_state_nxt = w_dispatch;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LD: begin
                mem_read    = 1'b1;
                w_state_nxt = LD_WAIT;
            end
            LD_WAIT: begin
                rsp_valid   = 1'b1;
                rsp_rdata   = w_load_data;
                w_state_nxt = IDLE;
            end
            ST_W: begin
                mem_write   = 1'b1;
                w_mem_wdata = r_wdata;
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
            RMW_RD: begin
                mem_read    = 1'b1;
                w_state_nxt = RMW_WR;
            end
            RMW_WR: begin
                mem_write   = 1'b1;
                w_mem_wdata = w_merge_data;
                rsp_valid   = 1'b1;
                w_state_nxt = IDLE;
            end
`ifdef LSU_MISALIGN_TRAP_EN
            ERR: begin
                rsp_valid   = 1'b1;
                rsp_err     = 1'b1;
                w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register, request capture and write-data hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_size      <= SIZE_B;
            r_unsigned  <= 1'b0;
            r_addr_lo   <= 2'b00;
            r_wdata     <= 32'h0000_0000;
            r_word_idx  <= '0;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_size     <= lsu_size_e'(req_size);
                r_unsigned <= req_unsigned;
                r_addr_lo  <= req_addr[1:0];
                r_wdata    <= req_wdata;
                r_word_idx <= req_addr[WORD_IDX_W+1:2];
            end
            // mem_wdata keeps the last written word between writes.
            if (mem_write) begin
                r_mem_wdata <= w_mem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Table-driven check of loads/stores through a behavioural word memory, with
// a response scoreboard and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          wr_cnt    = 0;
    int          cycle_cnt = 0;
    int          checks    = 0;
    int          failures  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          lat;
    } vec_t;
    vec_t vecs [0:19];

    always #5 clk = ~clk;

    load_store_unit #(.WORD_IDX_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, got, exp, cycle_cnt);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata;
        v.lat = (we && size == 2'b10) ? 1 : 2;
        return v;
    endfunction

    // Memory model: one-cycle read latency.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (mem_write) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_read) begin
            mem_rdata <= mem[mem_addr[9:0]];
        end
    end

    // Scoreboard and interface invariants, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (mem_read || mem_write) begin
                check("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
                check("addr_hi_zero", {10'b0, mem_addr[31:10]}, 32'd0);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 with nothing pending at cycle %0d", cycle_cnt);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    check("rsp_cycle", cycle_cnt, e.due);
                end
            end else begin
                check("rsp_quiet", rsp_rdata | {31'b0, rsp_err}, 32'd0);
            end
        end
    end

    task automatic push_exp(input logic [31:0] rdata, input logic err, input int due);
        exp_t e;
        e.rdata = rdata; e.err = err; e.due = due;
        sb.push_back(e);
    endtask

    // Offer one request; acc is the cycle number of the accept cycle.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, output int acc);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check("ready_in_idle", {31'b0, req_ready}, 32'd1);
        acc = cycle_cnt;
        push_exp(exp_rdata, exp_err, acc + lat);
        @(posedge clk);
        #1;
        // Scramble fields after the accept edge; they must be ignored.
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout: got %0d responses outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int n_acc;
        int acc_cyc [0:3];
        int wr0;

        for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        mem[5] <= 32'h8899AABB;
        mem[8] <= 32'h11223344;
        mem[9] <= 32'h8899AABB;

        vecs[0]  = mk(1'b0, 2'b00, 1'b0, 32'h16, 32'h0, 32'hFFFFFF99);
        vecs[1]  = mk(1'b0, 2'b00, 1'b1, 32'h16, 32'h0, 32'h00000099);
        vecs[2]  = mk(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 32'hFFFFAABB);
        vecs[3]  = mk(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 32'h00008899);
        vecs[4]  = mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h8899AABB);
        vecs[5]  = mk(1'b1, 2'b01, 1'b0, 32'h16, 32'h00001234, 32'h0);
        vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h1234AABB);
        vecs[7]  = mk(1'b1, 2'b00, 1'b0, 32'h15, 32'hFFFFFF5A, 32'h0);
        vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, 32'h0000005A);
        vecs[9]  = mk(1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'h00000012);
        vecs[10] = mk(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0);
        vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);
        vecs[12] = mk(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFFDE);
        vecs[13] = mk(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000DEAD);
        vecs[14] = mk(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000080, 32'h0);
        vecs[15] = mk(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFFFF80);
        vecs[16] = mk(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000BE80);
        vecs[17] = mk(1'b0, 2'b10, 1'b0, 32'hFFFF0014, 32'h0, 32'h12345ABB);
        vecs[18] = mk(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'h00001234);
        vecs[19] = mk(1'b0, 2'b00, 1'b1, 32'h14, 32'h0, 32'h000000BB);

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        check("reset_ready", {31'b0, req_ready}, 32'd0);
        check("reset_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("reset_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // Table-driven main function.
        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_rdata, 1'b0, vecs[i].lat, acc);
            if (i == 17) check("hi_addr_word_idx", mem_addr, 32'd5);
            wait_done();
        end

        // SH into the upper half of word 9 via read-modify-write.
        issue(1'b1, 2'b01, 1'b0, 32'h26, 32'h00001234, 32'h0, 1'b0, 2, acc);
        check("rmw_rd_read", {30'b0, mem_read, mem_write}, 32'd2);
        check("rmw_rd_addr", mem_addr, 32'd9);
        check("rmw_rd_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("rmw_wr_write", {30'b0, mem_read, mem_write}, 32'd1);
        check("rmw_wr_data", mem_wdata, 32'h1234AABB);
        @(posedge clk); #1;
        check("rmw_idle_ready", {31'b0, req_ready}, 32'd1);
        wait_done();

        // SW at 0x20: write and response in the same cycle.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1, acc);
        check("sw_write", {30'b0, mem_read, mem_write}, 32'd1);
        check("sw_addr", mem_addr, 32'd8);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_rsp", {31'b0, rsp_valid}, 32'd1);
        check("sw_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("sw_idle_ready", {31'b0, req_ready}, 32'd1);
        check("sw_wdata_hold", mem_wdata, 32'hDEADBEEF);
        wait_done();

        // Back-to-back loads with req_valid held: one accept every 3 cycles.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h24; req_wdata = 32'h0;
        n_acc = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready && n_acc < 4) begin
                push_exp(32'h1234AABB, 1'b0, cycle_cnt + 2);
                acc_cyc[n_acc] = cycle_cnt;
                n_acc++;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_accepts", n_acc, 32'd3);
        if (n_acc == 3) begin
            check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd3);
            check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd3);
        end
        wait_done();

        // Misaligned word, misaligned half, illegal size.
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1, acc);
        check("err_no_strobe", {30'b0, mem_read, mem_write}, 32'd0);
        wait_done();
        issue(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 32'h0, 1'b1, 1, acc);
        wait_done();
        issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'h0, 1'b1, 1, acc);
        wait_done();
`else
        issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 32'hDEADBEEF, 1'b0, 2, acc);
        check("misal_ld_read", {30'b0, mem_read, mem_write}, 32'd2);
        check("misal_ld_addr", mem_addr, 32'd8);
        wait_done();
        issue(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 32'h00005ABB, 1'b0, 2, acc);
        wait_done();
        issue(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, 32'h12345ABB, 1'b0, 2, acc);
        wait_done();
`endif

        // Reset during RMW_RD abandons the byte store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h24; req_wdata = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_rmw_read", {30'b0, mem_read, mem_write}, 32'd2);
        wr0 = wr_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'b0, req_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("rst_no_write", wr_cnt, wr0);
        check("rst_pending", sb.size(), 32'd0);

        check("mem_word5", mem[5], 32'h12345ABB);
        check("mem_word8", mem[8], 32'hDEADBEEF);
        check("mem_word9", mem[9], 32'h1234AABB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
